// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester word receiver and its matching encoder:
// receiver state encoding and the timing windows derived from the half-bit length.
package manchester_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        IDLE  = 2'd1,
        START = 2'd2,
        DATA  = 2'd3
    } state_t;

    // Earliest accepted start-bit mid edge (anything sooner is a line glitch).
    function automatic int start_lo(input int half_bit);
        return half_bit / 2;
    endfunction

    // Latest accepted start-bit mid edge.
    function automatic int start_hi(input int half_bit);
        return (3 * half_bit) / 2;
    endfunction

    // Earliest edge treated as a data mid-bit edge; earlier edges are bit boundaries.
    function automatic int mid_lo(input int half_bit);
        return (3 * half_bit) / 2;
    endfunction

    // Latest accepted data mid-bit edge; beyond this the frame is broken.
    function automatic int mid_hi(input int half_bit);
        return (5 * half_bit) / 2;
    endfunction

endpackage

// File: rtl/manchester_edge_sync.sv
// Brings the asynchronous serial line into the clk domain and flags its edges.
module manchester_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    // Two synchroniser stages followed by one delay stage for edge detection.
    always_comb begin
        meta_d = rx_in;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    // Synchroniser and delay registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~dly_q;
    assign fall  = ~sync_q & dly_q;

endmodule

// File: rtl/manchester_rx_word.sv
// Self-clocked Manchester word receiver: hunts for an idle gap, locks onto the
// start bit, samples each data bit at its mid-bit edge and hands complete words
// to the host through a ready/valid holding register with error accounting.
module manchester_rx_word
    import manchester_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int HALF_BIT = 8,
    parameter int IDLE_HB  = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             rx_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_error,
    output logic             overrun,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);

    localparam int START_LO = start_lo(HALF_BIT);
    localparam int START_HI = start_hi(HALF_BIT);
    localparam int MID_LO   = mid_lo(HALF_BIT);
    localparam int MID_HI   = mid_hi(HALF_BIT);
    // The timer only needs to reach one past the widest window to detect a timeout.
    localparam int TMR_MAX  = MID_HI + 1;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int IDLE_CYC = IDLE_HB * HALF_BIT;
    localparam int IDLE_W   = $clog2(IDLE_CYC + 1);
    localparam int CNT_W    = $clog2(WIDTH + 1);

    localparam logic [TMR_W-1:0] T_START_LO = TMR_W'(START_LO);
    localparam logic [TMR_W-1:0] T_START_HI = TMR_W'(START_HI);
    localparam logic [TMR_W-1:0] T_MID_LO   = TMR_W'(MID_LO);
    localparam logic [TMR_W-1:0] T_MID_HI   = TMR_W'(MID_HI);
    localparam logic [TMR_W-1:0] T_MAX      = TMR_W'(TMR_MAX);

    logic line_lvl, line_rise, line_fall;

    state_t             state_q,     state_d;
    logic [TMR_W-1:0]   timer_q,     timer_d;
    logic [IDLE_W-1:0]  idle_cnt_q,  idle_cnt_d;
    logic [WIDTH-1:0]   shift_q,     shift_d;
    logic [CNT_W-1:0]   bitcnt_q,    bitcnt_d;
    logic               done_q,      done_d;
    logic               frame_err_q, frame_err_d;
    logic [WIDTH-1:0]   data_q,      data_d;
    logic               valid_q,     valid_d;
    logic               overrun_q,   overrun_d;
    logic [ERR_W-1:0]   err_q,       err_d;
    logic [TMR_W-1:0]   timer_inc;

    manchester_edge_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_in (rx_in),
        .level (line_lvl),
        .rise  (line_rise),
        .fall  (line_fall)
    );

    // Receive FSM: idle qualification, start-bit check, mid-bit sampling and timeouts.
    // An accepted edge reloads the timer with 1 so that the timer value seen
    // alongside the next edge equals the clk distance between the two edges.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idle_cnt_d  = '0;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        timer_inc   = (timer_q == T_MAX) ? timer_q : timer_q + TMR_W'(1);

        case (state_q)
            HUNT: begin
                timer_d = '0;
                if (line_lvl) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_W'(IDLE_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            IDLE: begin
                if (line_rise) begin
                    state_d = START;
                    timer_d = TMR_W'(1);
                end
            end
            START: begin
                timer_d = timer_inc;
                if (line_fall && timer_q < T_START_LO) begin
                    state_d = HUNT;
                end else if (line_fall && timer_q <= T_START_HI) begin
                    state_d  = DATA;
                    timer_d  = TMR_W'(1);
                    bitcnt_d = '0;
                end else if (timer_q > T_START_HI) begin
                    state_d     = HUNT;
                    frame_err_d = 1'b1;
                end
            end
            DATA: begin
                timer_d = timer_inc;
                if ((line_rise || line_fall) && timer_q >= T_MID_LO && timer_q <= T_MID_HI) begin
                    shift_d    = shift_q << 1;
                    shift_d[0] = ~line_lvl;
                    timer_d    = TMR_W'(1);
                    bitcnt_d   = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = HUNT;
                        bitcnt_d = '0;
                        done_d   = 1'b1;
                    end
                end else if (timer_q > T_MID_HI) begin
                    state_d     = HUNT;
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        if (!enable) begin
            state_d     = HUNT;
            timer_d     = '0;
            idle_cnt_d  = '0;
            bitcnt_d    = '0;
            done_d      = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    // Holding register handshake, overrun detection and saturating error count.
    // The word finished by the FSM is loaded one clk later from the shift register.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        err_d     = err_q;
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
        if (done_q) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if ((frame_err_d || overrun_d) && err_q != '1) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            timer_q     <= '0;
            idle_cnt_q  <= '0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idle_cnt_q  <= idle_cnt_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            err_q       <= err_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_error = frame_err_q;
    assign overrun     = overrun_q;
    assign err_count   = err_q;
    assign busy        = (state_q == START) || (state_q == DATA);

endmodule

// File: tb/tb_manchester_rx_word.sv
// Directed bench for manchester_rx_word (WIDTH=32, HALF_BIT=8, IDLE_HB=4, ERR_W=8).
module tb_manchester_rx_word;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        rx_in;
    logic        data_ready;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_error;
    logic        overrun;
    logic [7:0]  err_count;
    logic        busy;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    // event monitor state (written only by the monitor)
    int          dv_tot = 0;
    int          dv_cyc = 0;
    logic [31:0] dv_word = '0;
    logic        dv_prev = 1'b0;
    int          fe_tot = 0;
    int          fe_cyc = 0;
    int          ov_tot = 0;

    // transmitter bookkeeping (written only by the stimulus tasks)
    int mid_cyc = 0;
    int ref_cyc = 0;

    manchester_rx_word #(
        .WIDTH    (32),
        .HALF_BIT (8),
        .IDLE_HB  (4),
        .ERR_W    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rx_in       (rx_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid && !dv_prev) begin
            dv_tot  = dv_tot + 1;
            dv_cyc  = cyc;
            dv_word = data_out;
        end
        dv_prev = data_valid;
        if (frame_error) begin
            fe_tot = fe_tot + 1;
            fe_cyc = cyc;
        end
        if (overrun) ov_tot = ov_tot + 1;
    end

    // hold the line at v for n clk; entered and left 1 time unit after a posedge
    task automatic drive_half(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] w, input int hb, input int drop_bit,
                              input int stop_bit, input bit rdy_pulse);
        logic b;
        drive_half(1'b1, hb);
        drive_half(1'b0, hb);
        for (int i = 0; i < 32; i++) begin
            b = w[31-i];
            if (i == stop_bit) begin
                rx_in = b;
                repeat (hb / 2) @(posedge clk);
                #1;
                return;
            end
            drive_half(b, hb);
            if (i == drop_bit) begin
                ref_cyc = mid_cyc;
                drive_half(b, hb);
            end else begin
                rx_in   = ~b;
                mid_cyc = cyc;
                for (int k = 1; k <= hb; k++) begin
                    @(posedge clk);
                    #1;
                    if (rdy_pulse && i == 31 && k == 3) data_ready = 1'b1;
                    if (rdy_pulse && i == 31 && k == 4) data_ready = 1'b0;
                end
            end
        end
        rx_in = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b1; rx_in = 1'b0; data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (data_out !== 32'h0) begin nfail++; $display("FAIL rst_data got %h exp 0", data_out); end
        nvec++; if (data_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid got %b exp 0", data_valid); end
        nvec++; if (frame_error !== 1'b0 || overrun !== 1'b0) begin nfail++; $display("FAIL rst_pulses got fe=%b ov=%b exp 0/0", frame_error, overrun); end
        nvec++; if (err_count !== 8'd0) begin nfail++; $display("FAIL rst_errcnt got %0d exp 0", err_count); end
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_busy got %b exp 0", busy); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_half(1'b0, 48);
    endtask

    task automatic test_basic;
        int dv0, fe0;
        dv0 = dv_tot; fe0 = fe_tot;
        send_frame(32'hA5A50F0F, 8, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (dv_tot - dv0 !== 1) begin nfail++; $display("FAIL basic_words got %0d exp 1", dv_tot - dv0); end
        nvec++; if (dv_word !== 32'hA5A50F0F) begin nfail++; $display("FAIL basic_data got %h exp a5a50f0f", dv_word); end
        nvec++; if (dv_cyc - mid_cyc !== 4) begin nfail++; $display("FAIL basic_latency got %0d exp 4", dv_cyc - mid_cyc); end
        nvec++; if (fe_tot !== fe0 || err_count !== 8'd0) begin nfail++; $display("FAIL basic_noerr got fe=%0d cnt=%0d exp 0/0", fe_tot - fe0, err_count); end
    endtask

    task automatic test_tolerance;
        int dv0, fe0;
        dv0 = dv_tot; fe0 = fe_tot;
        send_frame(32'hA5A50F0F, 6, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (dv_tot - dv0 !== 1 || dv_word !== 32'hA5A50F0F) begin nfail++; $display("FAIL tol_fast got n=%0d %h exp 1 a5a50f0f", dv_tot - dv0, dv_word); end
        nvec++; if (dv_cyc - mid_cyc !== 4) begin nfail++; $display("FAIL tol_fast_lat got %0d exp 4", dv_cyc - mid_cyc); end
        send_frame(32'hA5A50F0F, 10, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (dv_tot - dv0 !== 2 || dv_word !== 32'hA5A50F0F) begin nfail++; $display("FAIL tol_slow got n=%0d %h exp 2 a5a50f0f", dv_tot - dv0, dv_word); end
        nvec++; if (fe_tot !== fe0) begin nfail++; $display("FAIL tol_noerr got %0d exp 0", fe_tot - fe0); end
    endtask

    task automatic test_frame_error;
        int dv0, fe0;
        dv0 = dv_tot; fe0 = fe_tot;
        send_frame(32'hA5A50F0F, 8, 5, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (fe_tot - fe0 !== 1) begin nfail++; $display("FAIL ferr_pulses got %0d exp 1", fe_tot - fe0); end
        nvec++; if (fe_cyc - ref_cyc !== 24) begin nfail++; $display("FAIL ferr_timing got %0d exp 24", fe_cyc - ref_cyc); end
        nvec++; if (err_count !== 8'd1) begin nfail++; $display("FAIL ferr_count got %0d exp 1", err_count); end
        nvec++; if (dv_tot !== dv0) begin nfail++; $display("FAIL ferr_noword got %0d exp 0", dv_tot - dv0); end
        send_frame(32'h12345678, 8, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (dv_tot - dv0 !== 1 || dv_word !== 32'h12345678) begin nfail++; $display("FAIL ferr_recover got n=%0d %h exp 1 12345678", dv_tot - dv0, dv_word); end
    endtask

    task automatic test_overrun;
        int ov0;
        ov0 = ov_tot;
        data_ready = 1'b0;
        send_frame(32'hCAFE0001, 8, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (data_valid !== 1'b1 || data_out !== 32'hCAFE0001) begin nfail++; $display("FAIL ovr_first got v=%b %h exp 1 cafe0001", data_valid, data_out); end
        send_frame(32'h0BAD0002, 8, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (ov_tot - ov0 !== 1) begin nfail++; $display("FAIL ovr_pulse got %0d exp 1", ov_tot - ov0); end
        nvec++; if (data_valid !== 1'b1 || data_out !== 32'hCAFE0001) begin nfail++; $display("FAIL ovr_kept got v=%b %h exp 1 cafe0001", data_valid, data_out); end
        nvec++; if (err_count !== 8'd2) begin nfail++; $display("FAIL ovr_count got %0d exp 2", err_count); end
        send_frame(32'h600D0003, 8, -1, -1, 1'b1);
        nvec++; if (data_valid !== 1'b1 || data_out !== 32'h600D0003) begin nfail++; $display("FAIL ovr_sameclk got v=%b %h exp 1 600d0003", data_valid, data_out); end
        nvec++; if (ov_tot - ov0 !== 1 || err_count !== 8'd2) begin nfail++; $display("FAIL ovr_sameclk_noerr got ov=%0d cnt=%0d exp 1/2", ov_tot - ov0, err_count); end
        drive_half(1'b0, 8);
        nvec++; if (data_valid !== 1'b1) begin nfail++; $display("FAIL ovr_hold got %b exp 1", data_valid); end
        data_ready = 1'b1;
        drive_half(1'b0, 1);
        nvec++; if (data_valid !== 1'b0) begin nfail++; $display("FAIL ovr_accept got %b exp 0", data_valid); end
        drive_half(1'b0, 48);
    endtask

    task automatic test_glitch;
        int dv0, fe0;
        dv0 = dv_tot; fe0 = fe_tot;
        drive_half(1'b1, 2);
        drive_half(1'b0, 8);
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL glitch_busy got %b exp 0", busy); end
        send_frame(32'hDEADBEEF, 8, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (dv_tot !== dv0) begin nfail++; $display("FAIL glitch_nogap got %0d words exp 0", dv_tot - dv0); end
        nvec++; if (fe_tot !== fe0 || err_count !== 8'd2) begin nfail++; $display("FAIL glitch_noerr got fe=%0d cnt=%0d exp 0/2", fe_tot - fe0, err_count); end
        send_frame(32'hDEADBEEF, 8, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (dv_tot - dv0 !== 1 || dv_word !== 32'hDEADBEEF) begin nfail++; $display("FAIL glitch_recover got n=%0d %h exp 1 deadbeef", dv_tot - dv0, dv_word); end
    endtask

    task automatic test_enable;
        int dv0, fe0;
        dv0 = dv_tot; fe0 = fe_tot;
        data_ready = 1'b0;
        send_frame(32'h0F0F1234, 8, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        send_frame(32'h55AA55AA, 8, -1, 10, 1'b0);
        nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL en_busy_before got %b exp 1", busy); end
        enable = 1'b0;
        @(posedge clk);
        #1;
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL en_hunt got busy=%b exp 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        drive_half(1'b0, 48);
        nvec++; if (data_valid !== 1'b1 || data_out !== 32'h0F0F1234) begin nfail++; $display("FAIL en_hold got v=%b %h exp 1 0f0f1234", data_valid, data_out); end
        nvec++; if (fe_tot !== fe0 || err_count !== 8'd2) begin nfail++; $display("FAIL en_noerr got fe=%0d cnt=%0d exp 0/2", fe_tot - fe0, err_count); end
        data_ready = 1'b1;
        drive_half(1'b0, 2);
        send_frame(32'h89ABCDEF, 8, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (dv_tot - dv0 !== 2 || dv_word !== 32'h89ABCDEF) begin nfail++; $display("FAIL en_recover got n=%0d %h exp 2 89abcdef", dv_tot - dv0, dv_word); end
    endtask

    task automatic test_reset_mid;
        int dv0;
        data_ready = 1'b0;
        send_frame(32'h13579BDF, 8, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        send_frame(32'hFFFF0000, 8, -1, 10, 1'b0);
        nvec++; if (data_valid !== 1'b1 || busy !== 1'b1) begin nfail++; $display("FAIL rmid_before got v=%b busy=%b exp 1/1", data_valid, busy); end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++; if (data_valid !== 1'b0 || data_out !== 32'h0) begin nfail++; $display("FAIL rmid_word got v=%b %h exp 0 0", data_valid, data_out); end
        nvec++; if (err_count !== 8'd0 || busy !== 1'b0) begin nfail++; $display("FAIL rmid_ctrl got cnt=%0d busy=%b exp 0/0", err_count, busy); end
        rx_in = 1'b0;
        data_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_half(1'b0, 48);
        dv0 = dv_tot;
        send_frame(32'h2468ACE0, 8, -1, -1, 1'b0);
        drive_half(1'b0, 48);
        nvec++; if (dv_tot - dv0 !== 1 || dv_word !== 32'h2468ACE0) begin nfail++; $display("FAIL rmid_recover got n=%0d %h exp 1 2468ace0", dv_tot - dv0, dv_word); end
    endtask

    task automatic test_saturation;
        int fe0;
        fe0 = fe_tot;
        for (int n = 1; n <= 300; n++) begin
            drive_half(1'b1, 16);
            drive_half(1'b0, 40);
            if (n == 254) begin
                nvec++; if (err_count !== 8'd254) begin nfail++; $display("FAIL sat_254 got %0d exp 254", err_count); end
            end
        end
        nvec++; if (fe_tot - fe0 !== 300) begin nfail++; $display("FAIL sat_pulses got %0d exp 300", fe_tot - fe0); end
        nvec++; if (err_count !== 8'd255) begin nfail++; $display("FAIL sat_final got %0d exp 255", err_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tolerance();
        test_frame_error();
        test_overrun();
        test_glitch();
        test_enable();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
